// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: run/debug sequencer for the MIPS single-cycle core.
// Owns core reset and clock-enable; handles run/halt/step commands,
// PC breakpoint and halt-instruction stops, and counts enabled cycles.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   cmd_valid/cmd_op/cmd_ready command handshake (RUN/HALT/STEP/RESET_CORE)
//   bp_en, bp_addr             PC breakpoint
//   pc, instr                  current core PC and instruction
//   core_reset, core_en        core reset (registered), clock-enable (comb)
//   state, halted, halt_cause  sequencer status (registered)
//   cycle_count                saturating count of core_en cycles
module mips_run_ctrl #(
    parameter int          RESET_CYCLES = 2,
    parameter bit          AUTO_RUN     = 1'b1,
    parameter logic [31:0] HALT_INSTR   = 32'h0000000C,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    output logic             core_reset,
    output logic             core_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        S_RST  = 2'b00,
        S_HALT = 2'b01,
        S_RUN  = 2'b10,
        S_STEP = 2'b11
    } state_t;

    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam logic [RW-1:0] RLOAD = RW'(RESET_CYCLES);

    localparam logic [1:0] CAUSE_CMD = 2'b00;
    localparam logic [1:0] CAUSE_BP  = 2'b01;
    localparam logic [1:0] CAUSE_HI  = 2'b10;

    state_t        st_q, st_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          skip_q, skip_d;
    logic [1:0]    cause_d;
    logic          en_c;
    logic          cnt_clr;

    logic cmd_acc;
    logic op_run, op_halt, op_step, op_rstc;
    logic bp_hit, hi_hit, stop;

    assign cmd_ready = (st_q != S_RST);
    assign cmd_acc   = cmd_valid & cmd_ready;
    assign op_run    = cmd_acc & (cmd_op == 2'b00);
    assign op_halt   = cmd_acc & (cmd_op == 2'b01);
    assign op_step   = cmd_acc & (cmd_op == 2'b10);
    assign op_rstc   = cmd_acc & (cmd_op == 2'b11);

    assign bp_hit = bp_en & (pc == bp_addr);
    assign hi_hit = (instr == HALT_INSTR);
    // skip lets a resumed core execute the instruction it stopped on
    assign stop   = ~skip_q & (bp_hit | hi_hit);

    always_comb begin
        st_d    = st_q;
        rcnt_d  = rcnt_q;
        skip_d  = skip_q;
        cause_d = halt_cause;
        en_c    = 1'b0;
        cnt_clr = 1'b0;
        unique case (st_q)
            S_RST: begin
                if (rcnt_q <= RW'(1)) begin
                    st_d = AUTO_RUN ? S_RUN : S_HALT;
                end else begin
                    rcnt_d = rcnt_q - RW'(1);
                end
            end
            S_HALT: begin
                if (op_run) begin
                    st_d   = S_RUN;
                    skip_d = 1'b1;
                end else if (op_step) begin
                    st_d = S_STEP;
                end
            end
            S_RUN: begin
                skip_d = 1'b0;
                en_c   = ~stop & ~op_halt;
                // a stop outranks a coincident HALT command for the cause
                if (stop) begin
                    st_d    = S_HALT;
                    cause_d = bp_hit ? CAUSE_BP : CAUSE_HI;
                end else if (op_halt) begin
                    st_d    = S_HALT;
                    cause_d = CAUSE_CMD;
                end
            end
            S_STEP: begin
                en_c    = 1'b1;
                st_d    = S_HALT;
                cause_d = CAUSE_CMD;
            end
            default: begin
                st_d = S_RST;
            end
        endcase
        if (op_rstc) begin
            st_d    = S_RST;
            rcnt_d  = RLOAD;
            skip_d  = 1'b0;
            cause_d = CAUSE_CMD;
            cnt_clr = 1'b1;
        end
    end

    // reset in the same cycle suppresses any enable pulse
    assign core_en = en_c & ~reset;
    assign state   = st_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q        <= S_RST;
            rcnt_q      <= RLOAD;
            skip_q      <= 1'b0;
            core_reset  <= 1'b1;
            halted      <= 1'b0;
            halt_cause  <= CAUSE_CMD;
            cycle_count <= '0;
        end else begin
            st_q       <= st_d;
            rcnt_q     <= rcnt_d;
            skip_q     <= skip_d;
            core_reset <= (st_d == S_RST);
            halted     <= (st_d == S_HALT);
            halt_cause <= cause_d;
            if (cnt_clr) begin
                cycle_count <= '0;
            end else if (core_en && !(&cycle_count)) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: directed scenarios then random traffic,
// compared each cycle against a behavioural model of the sequencer.
module tb_mips_run_ctrl;

    localparam int          RC   = 2;
    localparam bit          AR   = 1'b1;
    localparam logic [31:0] HI   = 32'h0000000C;

    localparam int M_RST  = 0;
    localparam int M_HALT = 1;
    localparam int M_RUN  = 2;
    localparam int M_STEP = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        core_reset;
    logic        core_en;
    logic [1:0]  state;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    mips_run_ctrl #(
        .RESET_CYCLES(RC),
        .AUTO_RUN    (AR),
        .HALT_INSTR  (HI),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .instr      (instr),
        .core_reset (core_reset),
        .core_en    (core_en),
        .state      (state),
        .halted     (halted),
        .halt_cause (halt_cause),
        .cycle_count(cycle_count)
    );

    int total  = 0;
    int passed = 0;

    int          m_mode = -1;
    int          m_left = 0;
    bit          m_res  = 1'b0;
    int          m_cause = 0;
    logic [31:0] m_cnt  = '0;
    logic [31:0] tb_pc  = '0;
    logic [31:0] mem [64];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input bit r, input bit v, input logic [1:0] op);
        bit bp, hi, stp, acc, en;
        @(negedge clk);
        reset     = r;
        cmd_valid = v;
        cmd_op    = op;
        pc        = tb_pc;
        instr     = mem[tb_pc[7:2]];
        #1;
        bp  = bp_en && (tb_pc == bp_addr);
        hi  = (mem[tb_pc[7:2]] == HI);
        stp = (m_mode == M_RUN) && !m_res && (bp || hi);
        acc = v && (m_mode > M_RST);
        en  = !r && ((m_mode == M_STEP) ||
              ((m_mode == M_RUN) && !stp && !(acc && op == 2'b01)));
        if (m_mode >= 0) begin
            chk("state", state, m_mode);
            chk("core_reset", core_reset, m_mode == M_RST);
            chk("halted", halted, m_mode == M_HALT);
            chk("halt_cause", halt_cause, m_cause);
            chk("cycle_count", cycle_count, m_cnt);
            chk("core_en", core_en, en);
            chk("cmd_ready", cmd_ready, m_mode != M_RST);
        end
        @(posedge clk);
        if (m_mode == M_RST) tb_pc = '0;
        else if (en) tb_pc = tb_pc + 32'd4;
        if (r) begin
            m_mode  = M_RST;
            m_left  = RC;
            m_res   = 1'b0;
            m_cause = 0;
            m_cnt   = '0;
        end else begin
            if (en && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            case (m_mode)
                M_RST: begin
                    m_left--;
                    if (m_left == 0) m_mode = AR ? M_RUN : M_HALT;
                end
                M_HALT: begin
                    if (acc && op == 2'b00) begin
                        m_mode = M_RUN;
                        m_res  = 1'b1;
                    end else if (acc && op == 2'b10) begin
                        m_mode = M_STEP;
                    end
                end
                M_RUN: begin
                    m_res = 1'b0;
                    if (stp) begin
                        m_mode  = M_HALT;
                        m_cause = bp ? 1 : 2;
                    end else if (acc && op == 2'b01) begin
                        m_mode  = M_HALT;
                        m_cause = 0;
                    end
                end
                M_STEP: begin
                    m_mode  = M_HALT;
                    m_cause = 0;
                end
                default: ;
            endcase
            if (acc && op == 2'b11) begin
                m_mode  = M_RST;
                m_left  = RC;
                m_res   = 1'b0;
                m_cause = 0;
                m_cnt   = '0;
            end
        end
    endtask

    task automatic wait_halt(input string tag, input int lim);
        int n = 0;
        while (m_mode != M_HALT && n < lim) begin
            step(0, 0, 2'b00);
            n++;
        end
        #1;
        chk(tag, state, M_HALT);
    endtask

    initial begin
        logic [31:0] c0;
        int n;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        bp_en     = 1'b0;
        bp_addr   = '0;
        pc        = '0;
        instr     = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HI) mem[i] = 32'h0;
        end

        // power-up reset, then free run
        step(1, 0, 2'b00);
        repeat (12) step(0, 0, 2'b00);
        #1;
        chk("cnt_after_10_run", cycle_count, 10);
        chk("auto_run_state", state, M_RUN);

        // RESET_CORE mid-run; command during RST is refused
        step(0, 1, 2'b11);
        #1;
        chk("rc_core_reset", core_reset, 1);
        chk("rc_cnt_clear", cycle_count, 0);
        step(0, 1, 2'b10);
        #1;
        chk("rc_still_rst", state, M_RST);

        // breakpoint then halt instruction
        mem[8]  = HI;
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        wait_halt("bp_halt", 20);
        chk("bp_cause", halt_cause, 1);
        chk("bp_cnt", cycle_count, 4);
        step(0, 1, 2'b00);
        wait_halt("hi_halt", 20);
        chk("hi_cause", halt_cause, 2);
        chk("hi_cnt", cycle_count, 8);
        repeat (3) step(0, 0, 2'b00);
        #1;
        chk("hi_cnt_frozen", cycle_count, 8);
        step(0, 1, 2'b10);
        #1;
        chk("step_state", state, M_STEP);
        step(0, 0, 2'b00);
        #1;
        chk("step_cnt", cycle_count, 9);
        chk("step_cause", halt_cause, 0);
        chk("step_back_halt", state, M_HALT);

        // commands during RUN, command halt, three steps
        step(0, 1, 2'b00);
        repeat (3) step(0, 0, 2'b00);
        step(0, 1, 2'b00);
        step(0, 1, 2'b10);
        #1;
        chk("run_ignores_cmds", state, M_RUN);
        step(0, 1, 2'b01);
        #1;
        chk("cmd_halt_state", state, M_HALT);
        chk("cmd_halt_cause", halt_cause, 0);
        c0 = m_cnt;
        repeat (3) begin
            step(0, 1, 2'b10);
            step(0, 0, 2'b00);
        end
        #1;
        chk("three_steps", cycle_count, c0 + 32'd3);

        // HALT command coincident with breakpoint
        step(0, 1, 2'b11);
        bp_addr = 32'h8;
        n = 0;
        while (!(m_mode == M_RUN && tb_pc == 32'h8) && n < 20) begin
            step(0, 0, 2'b00);
            n++;
        end
        step(0, 1, 2'b01);
        #1;
        chk("bp_beats_halt_cmd", halt_cause, 1);

        // reset during STEP
        step(0, 1, 2'b10);
        step(1, 0, 2'b00);
        #1;
        chk("rst_in_step_state", state, M_RST);
        chk("rst_in_step_cnt", cycle_count, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                bp_en   = $urandom_range(0, 1) == 1;
                bp_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if ($urandom_range(0, 29) == 0)
                mem[$urandom_range(0, 63)] = HI;
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 7) == 0,
                 2'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
